// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared mode encodings for the immediate extension pipe
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extension (zero/sign/upper/branch)
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sign_ext;

  assign sign_ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    ext = '0;
    case (imm_mode_e'(mode))
      MODE_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_SIGN:   ext = sign_ext;
      MODE_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // branch offsets are word-aligned: sign-extended value times four
      MODE_BRANCH: ext = {sign_ext[OUT_W-3:0], 2'b00};
      default:     ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage valid/ready pipe around imm_ext_core
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] xfer_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_ext_q, s2_ext_d;
  logic [1:0]       s2_mode_q, s2_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] core_ext;
  logic             s2_adv;
  logic             s1_adv;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (s1_imm_q),
    .mode (s1_mode_q),
    .ext  (core_ext)
  );

  // S2 can take a new entry when empty or draining; S1 frees up whenever S2 advances
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_ext_d   = s2_ext_q;
    s2_mode_d  = s2_mode_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_imm_d  = in_imm;
        s1_mode_d = in_mode;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ext_d  = core_ext;
        s2_mode_d = s1_mode_q;
      end
    end
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_ext_q   <= '0;
      s2_mode_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_ext_q   <= s2_ext_d;
      s2_mode_q  <= s2_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_ext    = s2_ext_q;
  assign out_mode   = s2_mode_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ext;
  logic [1:0]  out_mode;
  logic [2:0]  xfer_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int n_out  = 0;
  logic [33:0] exp_q[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ext    (out_ext),
    .out_mode   (out_mode),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] ext;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'd0:    return 32'(imm);
      2'd1:    return 32'(s);
      2'd2:    return 32'(imm) * 32'h10000;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_out = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_valid && out_ready) begin
        chk("mon_xfer_count", 32'(xfer_count), 32'(n_out[2:0]));
        if (exp_q.size() == 0) begin
          chk("mon_extra_output", 32'd1, 32'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("mon_out_ext", out_ext, e[31:0]);
          chk("mon_out_mode", 32'(out_mode), 32'(e[33:32]));
        end
        n_out++;
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_mode, ref_ext(in_imm, in_mode)});
    end
  end

  initial begin
    vecs[0]  = '{16'h9FFF, 2'd0, 32'h00009FFF};
    vecs[1]  = '{16'h9FFF, 2'd1, 32'hFFFF9FFF};
    vecs[2]  = '{16'h7FFF, 2'd2, 32'h7FFF0000};
    vecs[3]  = '{16'h9FFF, 2'd3, 32'hFFFE7FFC};
    vecs[4]  = '{16'h7FFF, 2'd3, 32'h0001FFFC};
    vecs[5]  = '{16'h0000, 2'd1, 32'h00000000};
    vecs[6]  = '{16'h8000, 2'd1, 32'hFFFF8000};
    vecs[7]  = '{16'hFFFF, 2'd0, 32'h0000FFFF};
    vecs[8]  = '{16'hFFFF, 2'd2, 32'hFFFF0000};
    vecs[9]  = '{16'h8000, 2'd3, 32'hFFFE0000};
    vecs[10] = '{16'h0001, 2'd3, 32'h00000004};
    vecs[11] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
    vecs[12] = '{16'h1234, 2'd2, 32'h12340000};

    in_imm = '0;
    in_mode = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ext", out_ext, 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    do_reset();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // back-to-back table: vector c offered in cycle c appears after edge c+2
    out_ready = 1'b1;
    for (int c = 0; c < NV + 2; c++) begin
      if (c >= 2) begin
        chk("tbl_out_valid", 32'(out_valid), 32'd1);
        chk("tbl_out_ext", out_ext, vecs[c-2].ext);
        chk("tbl_out_mode", 32'(out_mode), 32'(vecs[c-2].mode));
        chk("tbl_xfer_count", 32'(xfer_count), 32'((c - 2) % 8));
      end
      if (c < NV) begin
        in_valid = 1'b1;
        in_imm   = vecs[c].imm;
        in_mode  = vecs[c].mode;
      end else begin
        in_valid = 1'b0;
      end
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    chk("tbl_drained", 32'(out_valid), 32'd0);
    chk("tbl_final_count", 32'(xfer_count), 32'(NV % 8));

    // backpressure: 4 values, out_ready low while the pipe fills
    do_reset();
    mon_en = 1'b1;
    in_valid = 1'b1; in_imm = 16'h1111; in_mode = 2'd0;
    step();
    chk("bp_in_ready_1", 32'(in_ready), 32'd1);
    in_imm = 16'h8222; in_mode = 2'd1;
    step();
    in_imm = 16'h3333; in_mode = 2'd2;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_ext", out_ext, 32'h00001111);
      chk("bp_hold_mode", 32'(out_mode), 32'd0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_imm = 16'hC444; in_mode = 2'd3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_delivered", 32'(n_out), 32'd4);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_out_valid_end", 32'(out_valid), 32'd0);

    // fill both stages, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h5555; in_mode = 2'd1;
    repeat (2) step();
    in_valid = 1'b0;
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    mon_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("mid_rst_out_ext", out_ext, 32'd0);
    step();
    reset = 1'b0;
    exp_q.delete();
    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      step();
    end

    // random handshakes against the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    chk("rand_no_loss", 32'(exp_q.size()), 32'd0);
    chk("rand_idle", 32'(out_valid), 32'd0);
    chk("rand_count", 32'(xfer_count), 32'(n_out % 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
